xor_initiator: RTL and testbench
================================

// Module: xor_initiator
// PURPOSE
//  Initiator end of the A/B/Y enable-ready protocol. Queues host operand pairs, drives them
//  onto the A and B request channels of a downstream responder, collects the Y result and
//  returns it to the host. Used as the stimulus master in front of XOR-style responders.
// PARAMETERS
//  DEPTH    4    command FIFO entries (power of 2, >=2)
//  CNT_W    16   width of completed-transaction counter
//  TIMEOUT  255  max cycles in WAIT_Y before abort (>=1)
// PORTS
//  clk        in   1      clock, all flops posedge
//  reset_n    in   1      async active-low reset
//  cmd_a      in   1      operand for A channel
//  cmd_b      in   1      operand for B channel
//  cmd_valid  in   1      host command valid
//  cmd_ready  out  1      FIFO not full
//  A_data     out  1      A operand
//  A_enable   out  1      A request valid
//  A_ready    in   1      responder accepts A
//  B_data     out  1      B operand
//  B_enable   out  1      B request valid
//  B_ready    in   1      responder accepts B
//  Y_data     in   1      result from responder
//  Y_enable   in   1      result valid
//  Y_ready    out  1      initiator accepts Y
//  rsp_data   out  1      captured result to host
//  rsp_valid  out  1      host result valid
//  rsp_ready  in   1      host accepts result
//  txn_count  out  CNT_W  completed transactions, wraps at 2^CNT_W
//  timeout_err out 1      sticky: WAIT_Y expired
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE, FIFO empty, all outputs 0 except cmd_ready=1.
//  - Handshakes: transfer when valid/enable && ready sampled high at posedge; data held
//    stable while enable high and not yet accepted.
//  - FIFO push on cmd_valid&&cmd_ready; cmd_ready=!full (no push-through when full, even if
//    pop same cycle). Pointers wrap modulo DEPTH; full/empty via extra pointer bit.
//  - FSM:
//    IDLE:   if FIFO non-empty -> pop, load A_data/B_data, set A_enable=B_enable=1 -> SEND.
//    SEND:   each enable drops independently the cycle after its own handshake; when both
//            accepted (same or different cycles) -> WAIT_Y. Earliest: 1 cycle in SEND.
//    WAIT_Y: Y_ready=1; on Y_enable -> capture Y_data into rsp_data, rsp_valid=1 next
//            cycle, txn_count+1 -> RESP. Timer counts cycles in WAIT_Y; at TIMEOUT with
//            no Y_enable -> timeout_err=1, Y_ready=0 -> IDLE, no rsp, no count.
//            Y_enable arriving in the TIMEOUT cycle wins over timeout.
//    RESP:   hold rsp_valid/rsp_data until rsp_ready -> IDLE (rsp_valid 0 next cycle).
//  - Y_enable outside WAIT_Y is ignored (Y_ready=0).
//  - Min latency cmd accept -> rsp_valid: 4 cycles with responders ready.
//  - One transaction in flight; FIFO keeps accepting while busy.
//  - timeout_err clears only on reset. txn_count wraps from all-ones to 0 silently.
//  - Reset mid-transaction: enables, Y_ready, rsp_valid drop asynchronously; FIFO flushed.
// STRUCTURE
//  - Shared package: FSM state enum (IDLE/SEND/WAIT_Y/RESP, 2-bit), default widths.
//  - Sub-module cmd_fifo (2-bit wide, DEPTH deep, sync push/pop, async reset);
//    FSM, timer and counter live in top.
// TESTING
//  1 Reset: reset_n=0 mid-SEND -> A_enable/B_enable/rsp_valid=0, cmd_ready=1, busy=0.
//  2 Single txn: cmd a=1,b=0, responders ready, Y=1 in WAIT_Y -> A_data=1,B_data=0
//    for 1 cycle, rsp_data=1 rsp_valid 4 cycles after cmd, txn_count=1.
//  3 Skewed ready: A_ready=1, B_ready held 0 for 3 cycles -> A_enable drops after 1
//    cycle, B_enable stays high 4 cycles, B_data stable, single WAIT_Y entry.
//  4 Full FIFO: 5 cmds with DEPTH=4, responders stalled -> cmd_ready=0 after 4th push
//    (1 already popped: after 5th); no entry lost, results in order.
//  5 Timeout: TIMEOUT=8, Y_enable never -> timeout_err=1 after 8 cycles in WAIT_Y,
//    no rsp_valid, txn_count unchanged, next cmd proceeds normally.
//  6 Backpressure/wrap: CNT_W=2, 5 txns, rsp_ready low 3 cycles each -> rsp held
//    stable, txn_count ends at 1.

Source files
------------

// File: rtl/xor_initiator_pkg.sv
// Shared types and default sizing for the A/B/Y initiator.
// Holds the FSM state encoding and the packed command format queued in the FIFO.
// No logic, only declarations.
package xor_initiator_pkg;

    localparam int unsigned DEF_DEPTH   = 4;
    localparam int unsigned DEF_CNT_W   = 16;
    localparam int unsigned DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_WAIT_Y = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // One queued host command: operand for the A channel and for the B channel.
    typedef struct packed {
        logic a;
        logic b;
    } cmd_t;

    localparam int unsigned CMD_W = $bits(cmd_t);

endpackage

// File: rtl/xor_initiator_cmd_fifo.sv
// Command FIFO: DEPTH x W synchronous push/pop, first-word-fall-through read data.
// Latency: a pushed word is visible on rdata_o (empty_o low) the cycle after the push.
// Backpressure: full_o blocks pushes (a pop in the same cycle does not free a slot early).
// Ports: clk/reset_n; push_i+wdata_i write side; pop_i+rdata_o read side; full_o/empty_o status.
module xor_initiator_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0] mem_q [DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push;
    logic         do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read once the pointers say they are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/xor_initiator.sv
// Initiator for the A/B/Y enable-ready protocol: queues host operand pairs, issues them on A/B,
// collects Y and returns it to the host. Latency cmd accept -> rsp_valid is 4 cycles minimum.
// Backpressure: cmd_ready=!fifo_full; A/B/rsp held until accepted; WAIT_Y aborts after TIMEOUT.
// Ports: host cmd_* in, rsp_* out; A_*/B_* request channels; Y_* result channel;
//        txn_count (wrapping), timeout_err (sticky), busy (FSM not idle).
module xor_initiator
    import xor_initiator_pkg::*;
#(
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_a,
    input  logic             cmd_b,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    output logic             A_data,
    output logic             A_enable,
    input  logic             A_ready,
    output logic             B_data,
    output logic             B_enable,
    input  logic             B_ready,
    input  logic             Y_data,
    input  logic             Y_enable,
    output logic             Y_ready,
    output logic             rsp_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [CNT_W-1:0] txn_count,
    output logic             timeout_err,
    output logic             busy
);

    localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_e           state_q, state_d;
    logic             a_data_q, a_data_d;
    logic             b_data_q, b_data_d;
    logic             a_en_q, a_en_d;
    logic             b_en_q, b_en_d;
    logic             rsp_data_q, rsp_data_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             terr_q, terr_d;

    cmd_t             cmd_in;
    cmd_t             fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;

    assign cmd_in = {cmd_a, cmd_b};

    xor_initiator_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (CMD_W)
    ) u_cmd_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (cmd_valid),
        .wdata_i (cmd_in),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        a_data_d   = a_data_q;
        b_data_d   = b_data_q;
        a_en_d     = a_en_q;
        b_en_d     = b_en_q;
        rsp_data_d = rsp_data_q;
        timer_d    = timer_q;
        cnt_d      = cnt_q;
        terr_d     = terr_q;
        fifo_pop   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    a_data_d = fifo_rdata.a;
                    b_data_d = fifo_rdata.b;
                    a_en_d   = 1'b1;
                    b_en_d   = 1'b1;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                // Each channel retires on its own handshake; leave once both have retired.
                if (a_en_q && A_ready) begin
                    a_en_d = 1'b0;
                end
                if (b_en_q && B_ready) begin
                    b_en_d = 1'b0;
                end
                if (!a_en_d && !b_en_d) begin
                    timer_d = '0;
                    state_d = ST_WAIT_Y;
                end
            end
            ST_WAIT_Y: begin
                // A result in the final timer cycle still counts as a completion.
                if (Y_enable) begin
                    rsp_data_d = Y_data;
                    cnt_d      = cnt_q + 1'b1;
                    state_d    = ST_RESP;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            a_data_q   <= 1'b0;
            b_data_q   <= 1'b0;
            a_en_q     <= 1'b0;
            b_en_q     <= 1'b0;
            rsp_data_q <= 1'b0;
            timer_q    <= '0;
            cnt_q      <= '0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_data_q   <= a_data_d;
            b_data_q   <= b_data_d;
            a_en_q     <= a_en_d;
            b_en_q     <= b_en_d;
            rsp_data_q <= rsp_data_d;
            timer_q    <= timer_d;
            cnt_q      <= cnt_d;
            terr_q     <= terr_d;
        end
    end

    // Y_ready and rsp_valid decode straight from the state register so reset kills them at once.
    assign cmd_ready   = !fifo_full;
    assign A_data      = a_data_q;
    assign A_enable    = a_en_q;
    assign B_data      = b_data_q;
    assign B_enable    = b_en_q;
    assign Y_ready     = (state_q == ST_WAIT_Y);
    assign rsp_data    = rsp_data_q;
    assign rsp_valid   = (state_q == ST_RESP);
    assign txn_count   = cnt_q;
    assign timeout_err = terr_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_xor_initiator.sv
module tb_xor_initiator;

    localparam int DEPTH   = 4;
    localparam int CNT_W   = 2;
    localparam int TIMEOUT = 8;
    localparam int CNT_MOD = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             cmd_a, cmd_b, cmd_valid, cmd_ready;
    logic             A_data, A_enable, A_ready;
    logic             B_data, B_enable, B_ready;
    logic             Y_data, Y_enable, Y_ready;
    logic             rsp_data, rsp_valid, rsp_ready;
    logic [CNT_W-1:0] txn_count;
    logic             timeout_err, busy;

    always #5 clk = ~clk;

    xor_initiator #(.DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .A_data(A_data), .A_enable(A_enable), .A_ready(A_ready),
        .B_data(B_data), .B_enable(B_enable), .B_ready(B_ready),
        .Y_data(Y_data), .Y_enable(Y_enable), .Y_ready(Y_ready),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .txn_count(txn_count), .timeout_err(timeout_err), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic checkn(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: operands in host acceptance order, and the results the host must see.
    typedef struct packed { logic a; logic b; } op_t;
    op_t cmd_q[$];
    bit  rsp_q[$];
    int  rsp_seen = 0;

    // Stimulus knobs. rdy_mode: 0 ready, 1 random, 2 stalled, 3 B held off 3 cycles.
    // rsp_mode: 0 ready, 1 three-cycle stall, 2 random. y_mode: 0 random delay, 1 last-cycle, 2 never, 3 immediate.
    int rdy_mode = 0;
    int rsp_mode = 0;
    int y_mode   = 3;
    bit skew_chk = 1'b0;

    // Responder state
    bit got_a, got_b, a_v, b_v, pend, drop_pend;
    bit prev_a_stall, prev_b_stall, prev_a_hs, prev_b_hs, prev_a_dat, prev_b_dat;
    int y_wait, y_delay, b_en_cycles, yr_cycles;

    initial begin : responder
        op_t op;
        A_ready = 1'b0; B_ready = 1'b0; Y_enable = 1'b0; Y_data = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                A_ready = 1'b0; B_ready = 1'b0; Y_enable = 1'b0; Y_data = 1'b0;
                got_a = 0; got_b = 0; pend = 0; drop_pend = 0; b_en_cycles = 0;
                prev_a_stall = 0; prev_b_stall = 0; prev_a_hs = 0; prev_b_hs = 0;
            end else begin
                if (prev_a_stall) begin
                    check1("a_hold_en", A_enable, 1'b1);
                    check1("a_hold_dat", A_data, prev_a_dat);
                end
                if (prev_b_stall) begin
                    check1("b_hold_en", B_enable, 1'b1);
                    check1("b_hold_dat", B_data, prev_b_dat);
                end
                if (prev_a_hs) check1("a_drop", A_enable, 1'b0);
                if (prev_b_hs) check1("b_drop", B_enable, 1'b0);

                case (rdy_mode)
                    0: begin A_ready = 1'b1; B_ready = 1'b1; end
                    1: begin A_ready = 1'($urandom_range(0, 1)); B_ready = 1'($urandom_range(0, 1)); end
                    2: begin A_ready = 1'b0; B_ready = 1'b0; end
                    default: begin A_ready = 1'b1; B_ready = (b_en_cycles >= 3); end
                endcase

                Y_enable = 1'b0;
                Y_data   = 1'($urandom_range(0, 1));
                if (Y_ready) begin
                    if (pend) begin
                        if (y_wait == y_delay) begin
                            Y_enable = 1'b1;
                            Y_data   = a_v ^ b_v;
                        end
                        y_wait++;
                    end else if (drop_pend) begin
                        yr_cycles++;
                    end
                end else begin
                    // Junk on Y while the initiator is not listening must be ignored.
                    Y_enable = 1'($urandom_range(0, 1));
                    if (drop_pend && yr_cycles > 0) begin
                        checkn("timeout_len", yr_cycles, TIMEOUT);
                        check1("timeout_flag", timeout_err, 1'b1);
                        checkn("timeout_cnt", int'(txn_count), rsp_seen % CNT_MOD);
                        drop_pend = 0;
                    end
                end

                prev_a_hs    = A_enable && A_ready;
                prev_b_hs    = B_enable && B_ready;
                prev_a_stall = A_enable && !A_ready;
                prev_b_stall = B_enable && !B_ready;
                prev_a_dat   = A_data;
                prev_b_dat   = B_data;
                if (prev_a_hs) begin got_a = 1; a_v = A_data; end
                if (prev_b_stall) b_en_cycles++;
                if (prev_b_hs) begin
                    if (skew_chk) checkn("skew_b_cycles", b_en_cycles + 1, 4);
                    b_en_cycles = 0;
                    got_b = 1;
                    b_v = B_data;
                end
                if (Y_enable && Y_ready) pend = 0;

                if (got_a && got_b) begin
                    got_a = 0; got_b = 0;
                    checkn("txn_expected", int'(cmd_q.size() > 0), 1);
                    if (cmd_q.size() > 0) begin
                        op = cmd_q.pop_front();
                        check1("op_a", a_v, op.a);
                        check1("op_b", b_v, op.b);
                        if (y_mode == 2) begin
                            drop_pend = 1; yr_cycles = 0;
                        end else begin
                            pend = 1; y_wait = 0;
                            y_delay = (y_mode == 1) ? TIMEOUT - 1 :
                                      (y_mode == 3) ? 0 : int'($urandom_range(0, 3));
                            rsp_q.push_back(op.a ^ op.b);
                        end
                    end
                end
            end
        end
    end

    // Host-side monitor: drives rsp_ready, pops the scoreboard on every result handshake.
    initial begin : monitor
        int  low_cnt;
        bit  prev_hold, prev_dat, exp;
        rsp_ready = 1'b0; low_cnt = 0; prev_hold = 0; prev_dat = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                rsp_ready = 1'b0; low_cnt = 0; prev_hold = 0;
            end else begin
                if (prev_hold) begin
                    check1("rsp_hold_valid", rsp_valid, 1'b1);
                    check1("rsp_hold_data", rsp_data, prev_dat);
                end
                case (rsp_mode)
                    0: rsp_ready = 1'b1;
                    1: rsp_ready = rsp_valid && (low_cnt >= 3);
                    default: rsp_ready = 1'($urandom_range(0, 1));
                endcase
                if (rsp_valid && !rsp_ready) low_cnt++;
                prev_hold = rsp_valid && !rsp_ready;
                prev_dat  = rsp_data;
                if (rsp_valid && rsp_ready) begin
                    low_cnt = 0;
                    checkn("rsp_expected", int'(rsp_q.size() > 0), 1);
                    if (rsp_q.size() > 0) begin
                        exp = rsp_q.pop_front();
                        check1("rsp_data", rsp_data, exp);
                        rsp_seen++;
                        checkn("txn_count", int'(txn_count), rsp_seen % CNT_MOD);
                    end
                end
            end
        end
    end

    task automatic send(input bit a, input bit b);
        int  n = 0;
        op_t op;
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b;
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (cmd_ready) begin
            op.a = a; op.b = b;
            cmd_q.push_back(op);
        end else begin
            check1("cmd_accept", cmd_ready, 1'b1);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((cmd_q.size() != 0 || rsp_q.size() != 0 || busy || pend || drop_pend) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkn(name, int'(n < 2000), 1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog no completion t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int lat;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_a = 1'b0; cmd_b = 1'b0;
        repeat (3) @(negedge clk);
        check1("rst_cmd_ready", cmd_ready, 1'b1);
        check1("rst_a_en", A_enable, 1'b0);
        check1("rst_b_en", B_enable, 1'b0);
        check1("rst_a_dat", A_data, 1'b0);
        check1("rst_b_dat", B_data, 1'b0);
        check1("rst_y_rdy", Y_ready, 1'b0);
        check1("rst_rsp_vld", rsp_valid, 1'b0);
        check1("rst_rsp_dat", rsp_data, 1'b0);
        checkn("rst_txn", int'(txn_count), 0);
        check1("rst_terr", timeout_err, 1'b0);
        check1("rst_busy", busy, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single transaction, everything ready, Y returned immediately.
        rdy_mode = 0; rsp_mode = 0; y_mode = 3;
        send(1'b1, 1'b0);
        lat = 1;
        @(negedge clk);
        lat = 2;
        check1("single_a_en", A_enable, 1'b1);
        check1("single_a_dat", A_data, 1'b1);
        check1("single_b_dat", B_data, 1'b0);
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkn("single_latency", lat, 4);
        check1("single_rsp", rsp_data, 1'b1);
        checkn("single_txn", int'(txn_count), 1);
        drain("drain_single");

        // B held off for 3 cycles while A accepts at once.
        rdy_mode = 3; skew_chk = 1'b1; y_mode = 0;
        send(1'b0, 1'b1);
        drain("drain_skew0");
        send(1'b1, 1'b1);
        drain("drain_skew1");
        skew_chk = 1'b0;

        // Fill the FIFO behind a stalled transaction.
        rdy_mode = 2;
        for (int i = 0; i < 5; i++) begin
            send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (i == 3) check1("fifo_not_full_4", cmd_ready, 1'b1);
        end
        check1("fifo_full_5", cmd_ready, 1'b0);
        cmd_valid = 1'b1; cmd_a = 1'b1; cmd_b = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check1("fifo_full_hold", cmd_ready, 1'b0);
        end
        rdy_mode = 0;
        send(1'b1, 1'b0);
        drain("drain_full");

        // Y in the final timer cycle wins over the timeout.
        y_mode = 1;
        send(1'b1, 1'b1);
        drain("drain_late_y");
        check1("late_y_no_terr", timeout_err, 1'b0);

        // Responder never answers.
        y_mode = 2;
        send(1'b1, 1'b0);
        drain("drain_timeout");
        y_mode = 0;
        send(1'b0, 1'b1);
        drain("drain_after_timeout");
        check1("terr_sticky", timeout_err, 1'b1);

        // Host backpressure with counter wrap.
        rsp_mode = 1;
        for (int i = 0; i < 5; i++) send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drain("drain_backpressure");
        checkn("wrap_txn", int'(txn_count), rsp_seen % CNT_MOD);

        // Randomised traffic.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: rdy_mode = 0;
                1: rdy_mode = 1;
                default: rdy_mode = 3;
            endcase
            rsp_mode = int'($urandom_range(0, 2));
            send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        rdy_mode = 0;
        drain("drain_random");

        // Reset while in SEND.
        rdy_mode = 2;
        send(1'b1, 1'b1);
        lat = 0;
        while (!A_enable && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check1("pre_reset_a_en", A_enable, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check1("mid_rst_a_en", A_enable, 1'b0);
        check1("mid_rst_b_en", B_enable, 1'b0);
        check1("mid_rst_rsp_vld", rsp_valid, 1'b0);
        check1("mid_rst_y_rdy", Y_ready, 1'b0);
        check1("mid_rst_cmd_rdy", cmd_ready, 1'b1);
        check1("mid_rst_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
